// File: rtl/charlieplex_pkg.sv
// Shared constants and types for the charlieplex matrix loader and driver.
package charlieplex_pkg;

  localparam int unsigned NUM_LEDS        = 144;
  localparam int unsigned LEDS_PER_MATRIX = 72;
  localparam int unsigned BYTES_PER_FRAME = NUM_LEDS / 8;
  localparam int unsigned BYTE_IDX_W      = 5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    PENDING = 2'd2
  } loader_state_e;

endpackage

// File: rtl/led_shadow_buf.sv
// Byte-addressed frame shadow register with a full-width parallel read port.
module led_shadow_buf
  import charlieplex_pkg::*;
#(
  parameter int unsigned NUM_BYTES = BYTES_PER_FRAME
) (
  input  logic                   clock,
  input  logic                   aclr_n,
  input  logic                   we,
  input  logic [BYTE_IDX_W-1:0]  idx,
  input  logic [7:0]             data,
  output logic [8*NUM_BYTES-1:0] frame
);

  logic [7:0] mem_q [NUM_BYTES];

  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      for (int unsigned i = 0; i < NUM_BYTES; i++) mem_q[i] <= '0;
    end else if (we) begin
      for (int unsigned i = 0; i < NUM_BYTES; i++) begin
        if (idx == BYTE_IDX_W'(i)) mem_q[i] <= data;
      end
    end
  end

  for (genvar g = 0; g < NUM_BYTES; g++) begin : g_pack
    assign frame[8*g +: 8] = mem_q[g];
  end

endmodule

// File: rtl/led_frame_loader.sv
// Assembles byte-streamed LED frames into a shadow buffer and commits them
// to led_state only at end of scan, so the driver never sees a torn frame.
module led_frame_loader #(
  parameter int unsigned NUM_LEDS        = charlieplex_pkg::NUM_LEDS,
  parameter int unsigned BYTES_PER_FRAME = NUM_LEDS / 8,
  parameter int unsigned SYNC_SWAP       = 1
) (
  input  logic                clock,
  input  logic                aclr_n,
  input  logic [7:0]          wr_data,
  input  logic                wr_valid,
  input  logic                wr_sof,
  output logic                wr_ready,
  input  logic                scan_sync,
  output logic [NUM_LEDS-1:0] led_state,
  output logic                frame_pending,
  output logic                frame_done,
  output logic                frame_err
);

  import charlieplex_pkg::*;

  localparam int unsigned         IDX_W    = BYTE_IDX_W;
  localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(BYTES_PER_FRAME - 1);

  if ((NUM_LEDS % 8) != 0 || BYTES_PER_FRAME != NUM_LEDS / 8 ||
      BYTES_PER_FRAME > (1 << IDX_W)) begin : g_bad_cfg
    $error("led_frame_loader: NUM_LEDS must be a multiple of 8 and fit the byte index");
  end

  loader_state_e       state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [IDX_W-1:0]    buf_idx;
  logic                buf_we;
  logic                accept;
  logic                commit;
  logic                err_d;
  logic [NUM_LEDS-1:0] shadow;

  assign wr_ready      = (state_q != PENDING);
  assign frame_pending = (state_q == PENDING) && (SYNC_SWAP != 0);
  assign accept        = wr_valid && wr_ready;

  led_shadow_buf #(.NUM_BYTES(BYTES_PER_FRAME)) u_shadow (
    .clock (clock),
    .aclr_n(aclr_n),
    .we    (buf_we),
    .idx   (buf_idx),
    .data  (wr_data),
    .frame (shadow)
  );

  // Next-state, shadow write steering and pulse decode.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    buf_we  = 1'b0;
    buf_idx = idx_q;
    commit  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (wr_sof) begin
            buf_we  = 1'b1;
            buf_idx = '0;
            idx_d   = IDX_W'(1);
            state_d = LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      LOAD: begin
        if (accept) begin
          buf_we = 1'b1;
          if (wr_sof) begin
            // Restart: earlier bytes of the abandoned frame stay as stale data.
            err_d   = 1'b1;
            buf_idx = '0;
            idx_d   = IDX_W'(1);
          end else if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = PENDING;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      PENDING: begin
        if (scan_sync || SYNC_SWAP == 0) begin
          commit  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      led_state  <= '0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      frame_done <= commit;
      frame_err  <= err_d;
      if (commit) led_state <= shadow;
    end
  end

endmodule

// File: tb/tb_led_frame_loader.sv
// Randomized self-checking bench for led_frame_loader (sync-swap and immediate builds).
module tb_led_frame_loader;
  import charlieplex_pkg::*;

  localparam int unsigned NB = BYTES_PER_FRAME;
  localparam int unsigned NL = NUM_LEDS;

  logic clock  = 1'b0;
  logic aclr_n = 1'b0;
  always #5 clock = ~clock;

  // Index 0: SYNC_SWAP=1 build, index 1: SYNC_SWAP=0 build.
  logic [7:0]    wr_data       [2];
  logic          wr_valid      [2];
  logic          wr_sof        [2];
  logic          scan_sync     [2];
  logic          wr_ready      [2];
  logic          frame_pending [2];
  logic          frame_done    [2];
  logic          frame_err     [2];
  logic [NL-1:0] led_state     [2];

  led_frame_loader #(.SYNC_SWAP(1)) u_dut_sync (
    .clock(clock), .aclr_n(aclr_n), .wr_data(wr_data[0]), .wr_valid(wr_valid[0]),
    .wr_sof(wr_sof[0]), .wr_ready(wr_ready[0]), .scan_sync(scan_sync[0]),
    .led_state(led_state[0]), .frame_pending(frame_pending[0]),
    .frame_done(frame_done[0]), .frame_err(frame_err[0]));

  led_frame_loader #(.SYNC_SWAP(0)) u_dut_imm (
    .clock(clock), .aclr_n(aclr_n), .wr_data(wr_data[1]), .wr_valid(wr_valid[1]),
    .wr_sof(wr_sof[1]), .wr_ready(wr_ready[1]), .scan_sync(scan_sync[1]),
    .led_state(led_state[1]), .frame_pending(frame_pending[1]),
    .frame_done(frame_done[1]), .frame_err(frame_err[1]));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [NL-1:0] got, input logic [NL-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Frame-level reference model: byte position in the frame being assembled,
  // a shadow byte array, and whether a complete frame awaits commit.
  int            ss      [2] = '{1, 0};
  logic [7:0]    m_shadow [2][NB];
  logic [NL-1:0] m_led   [2];
  int            m_pos   [2];
  bit            m_pend  [2];
  bit            m_done  [2];
  bit            m_err   [2];
  bit            m_acc   [2];
  logic [7:0]    fr      [NB];

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      for (int b = 0; b < int'(NB); b++) m_shadow[i][b] = 8'h00;
      m_led[i]  = '0;
      m_pos[i]  = -1;
      m_pend[i] = 1'b0;
      m_done[i] = 1'b0;
      m_err[i]  = 1'b0;
      m_acc[i]  = 1'b0;
    end
  endfunction

  function automatic void model_edge(int i, bit v, bit sof, logic [7:0] d, bit sync);
    m_done[i] = 1'b0;
    m_err[i]  = 1'b0;
    m_acc[i]  = 1'b0;
    if (m_pend[i]) begin
      if (sync || ss[i] == 0) begin
        for (int b = 0; b < int'(NB); b++) m_led[i][8*b +: 8] = m_shadow[i][b];
        m_done[i] = 1'b1;
        m_pend[i] = 1'b0;
      end
    end else if (v) begin
      m_acc[i] = 1'b1;
      if (sof) begin
        if (m_pos[i] > 0) m_err[i] = 1'b1;
        m_shadow[i][0] = d;
        m_pos[i] = 1;
      end else if (m_pos[i] < 0) begin
        m_err[i] = 1'b1;
      end else begin
        m_shadow[i][m_pos[i]] = d;
        m_pos[i]++;
      end
      if (m_pos[i] == int'(NB)) begin
        m_pend[i] = 1'b1;
        m_pos[i]  = -1;
      end
    end
  endfunction

  task automatic check_outputs();
    for (int i = 0; i < 2; i++) begin
      check($sformatf("wr_ready[%0d]", i), NL'(wr_ready[i]), NL'(!m_pend[i]));
      check($sformatf("frame_pending[%0d]", i), NL'(frame_pending[i]), NL'(m_pend[i] && ss[i] != 0));
      check($sformatf("frame_done[%0d]", i), NL'(frame_done[i]), NL'(m_done[i]));
      check($sformatf("frame_err[%0d]", i), NL'(frame_err[i]), NL'(m_err[i]));
      check($sformatf("led_state[%0d]", i), led_state[i], m_led[i]);
    end
  endtask

  task automatic step(input int w, input bit v, input bit sof, input logic [7:0] d, input bit sync);
    @(negedge clock);
    for (int i = 0; i < 2; i++) begin
      wr_valid[i]  = (i == w) && v;
      wr_sof[i]    = (i == w) && sof;
      wr_data[i]   = (i == w) ? d : 8'h00;
      scan_sync[i] = (i == w) && sync;
    end
    check_outputs();
    @(posedge clock);
    for (int i = 0; i < 2; i++)
      model_edge(i, (i == w) && v, (i == w) && sof, (i == w) ? d : 8'h00, (i == w) && sync);
  endtask

  // Holds the byte until accepted; pulses scan_sync once while back-pressured.
  task automatic send_byte(input int w, input bit sof, input logic [7:0] d);
    for (int t = 0; t < 40; t++) begin
      step(w, 1'b1, sof, d, (t == 2));
      if (m_acc[w]) return;
    end
    check("accept_timeout", NL'(0), NL'(1));
  endtask

  task automatic send_frame(input int w, input bit gaps);
    for (int b = 0; b < int'(NB); b++) begin
      if (gaps && $urandom_range(0, 3) == 0)
        step(w, 1'b0, 1'b0, 8'($urandom), 1'($urandom_range(0, 1)));
      send_byte(w, (b == 0), fr[b]);
    end
  endtask

  task automatic idle(input int w, input int n, input int sync_at);
    for (int k = 0; k < n; k++) step(w, 1'b0, 1'b0, 8'h00, (k == sync_at));
  endtask

  task automatic do_reset();
    @(negedge clock);
    aclr_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      wr_valid[i] = 1'b0; wr_sof[i] = 1'b0; wr_data[i] = 8'h00; scan_sync[i] = 1'b0;
    end
    model_reset();
    #1 check_outputs();
    @(negedge clock);
    check_outputs();
    aclr_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      wr_valid[i] = 1'b0; wr_sof[i] = 1'b0; wr_data[i] = 8'h00; scan_sync[i] = 1'b0;
    end
    model_reset();
    do_reset();

    // Reset in the middle of a frame, then an all-ones frame.
    for (int b = 0; b < 5; b++) send_byte(0, (b == 0), 8'hC3);
    do_reset();
    for (int b = 0; b < int'(NB); b++) fr[b] = 8'hFF;
    send_frame(0, 1'b0);
    idle(0, 2, -1);
    idle(0, 3, 0);
    #1 check("all_ones", led_state[0], {NL{1'b1}});

    // Counting frame with sync three cycles after the last byte.
    for (int b = 0; b < int'(NB); b++) fr[b] = 8'(b + 1);
    send_frame(0, 1'b0);
    idle(0, 3, -1);
    idle(0, 3, 0);
    #1 check("first_byte", NL'(led_state[0][7:0]), NL'(8'h01));
    check("last_byte", NL'(led_state[0][NL-1 -: 8]), NL'(8'h12));

    // Back-pressure: second frame streamed while the first is pending.
    for (int b = 0; b < int'(NB); b++) fr[b] = 8'(8'hA0 + b);
    send_frame(0, 1'b0);
    for (int b = 0; b < int'(NB); b++) fr[b] = 8'(8'h30 + 3 * b);
    send_frame(0, 1'b0);
    idle(0, 4, 2);

    // Protocol errors: stray byte in IDLE, sof re-asserted at byte 9.
    send_byte(0, 1'b0, 8'hAA);
    idle(0, 2, -1);
    for (int b = 0; b < 9; b++) send_byte(0, (b == 0), 8'h77);
    for (int b = 0; b < int'(NB); b++) fr[b] = 8'(8'h5A ^ b);
    send_frame(0, 1'b0);
    idle(0, 4, 1);

    // scan_sync coincident with the last byte is ignored; sync in IDLE too.
    for (int b = 0; b < int'(NB) - 1; b++) send_byte(0, (b == 0), 8'(8'hE0 + b));
    step(0, 1'b1, 1'b0, 8'hEE, 1'b1);
    idle(0, 3, -1);
    idle(0, 3, 0);
    idle(0, 4, 1);

    // Immediate-commit build.
    for (int b = 0; b < int'(NB); b++) fr[b] = 8'h55;
    send_frame(1, 1'b0);
    idle(1, 3, -1);
    #1 check("imm_55", led_state[1], {NB{8'h55}});
    for (int b = 0; b < int'(NB); b++) fr[b] = 8'(b * 7);
    send_frame(1, 1'b0);
    send_frame(1, 1'b0);
    idle(1, 3, -1);

    // Randomized traffic on both builds.
    for (int it = 0; it < 60; it++) begin
      int w;
      int r;
      w = int'($urandom_range(0, 1));
      r = int'($urandom_range(0, 9));
      for (int b = 0; b < int'(NB); b++) fr[b] = 8'($urandom);
      if (r == 0) send_byte(w, 1'b0, 8'($urandom));
      if (r == 1) begin
        int k;
        k = int'($urandom_range(1, 16));
        for (int b = 0; b < k; b++) send_byte(w, (b == 0), 8'($urandom));
      end
      send_frame(w, 1'b1);
      idle(w, int'($urandom_range(0, 4)), int'($urandom_range(0, 5)));
    end
    idle(0, 3, 0);
    idle(1, 3, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
